// File: rtl/tlc_pkg.sv
// tlc_pkg: phase encoding, lamp codes and counter width shared by the traffic light controller
package tlc_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] LAMP_RED    = 3'b100;
  localparam logic [2:0] LAMP_YELLOW = 3'b010;
  localparam logic [2:0] LAMP_GREEN  = 3'b001;
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5
  } phase_e;
  function automatic logic [CNT_W-1:0] len_m1(int p);
    return (p <= 1) ? '0 : CNT_W'(p - 1);
  endfunction
endpackage

// File: rtl/tlc_phase_timer.sv
// tlc_phase_timer: loadable 8-bit phase down-counter with zero flag
import tlc_pkg::*;
module tlc_phase_timer #(
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);
  logic [CNT_W-1:0] count_q, count_d;
  always_comb count_d = load_i ? load_val_i : (count_q != '0) ? count_q - 1'b1 : count_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) count_q <= RST_VAL;
    else      count_q <= count_d;
  assign zero_o = (count_q == '0);
endmodule

// File: rtl/traffic_light_controller.sv
// traffic_light_controller: fixed-time two-way Moore FSM; TLC_ALL_RED_EN adds all-red clearance phases
import tlc_pkg::*;
module traffic_light_controller #(
  parameter int GREEN_CYCLES  = 5,
  parameter int YELLOW_CYCLES = 2,
  parameter int ALLRED_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] ns,
  output logic [2:0] ew
);
  localparam logic [CNT_W-1:0] G_M1 = len_m1(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] Y_M1 = len_m1(YELLOW_CYCLES);
  localparam logic [CNT_W-1:0] A_M1 = len_m1(ALLRED_CYCLES);
`ifdef TLC_ALL_RED_EN
  localparam phase_e AFTER_NS_Y = ALL_RED_1;
  localparam phase_e AFTER_EW_Y = ALL_RED_2;
`else
  localparam phase_e AFTER_NS_Y = EW_GREEN;
  localparam phase_e AFTER_EW_Y = NS_GREEN;
`endif
  phase_e state_q, state_d;
  logic zero, load;
  logic [CNT_W-1:0] load_val;
  tlc_phase_timer #(.RST_VAL(G_M1)) u_timer (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .load_val_i(load_val),
    .zero_o    (zero)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= NS_GREEN;
    else      state_q <= state_d;
  always_comb begin
    state_d = NS_GREEN;
    case (state_q)
      NS_GREEN:  state_d = zero ? NS_YELLOW  : NS_GREEN;
      NS_YELLOW: state_d = zero ? AFTER_NS_Y : NS_YELLOW;
      ALL_RED_1: state_d = zero ? EW_GREEN   : ALL_RED_1;
      EW_GREEN:  state_d = zero ? EW_YELLOW  : EW_GREEN;
      EW_YELLOW: state_d = zero ? AFTER_EW_Y : EW_YELLOW;
      ALL_RED_2: state_d = zero ? NS_GREEN   : ALL_RED_2;
      default:   state_d = NS_GREEN;
    endcase
  end
  // every phase change, including recovery from an illegal encoding, reloads the timer
  assign load = (state_d != state_q);
  always_comb begin
    load_val = G_M1;
    case (state_d)
      NS_YELLOW, EW_YELLOW: load_val = Y_M1;
      ALL_RED_1, ALL_RED_2: load_val = A_M1;
      default:              load_val = G_M1;
    endcase
  end
  always_comb begin
    ns = LAMP_RED;
    ew = LAMP_RED;
    case (state_q)
      NS_GREEN:  ns = LAMP_GREEN;
      NS_YELLOW: ns = LAMP_YELLOW;
      EW_GREEN:  ew = LAMP_GREEN;
      EW_YELLOW: ew = LAMP_YELLOW;
      default:   ns = LAMP_RED;
    endcase
  end
endmodule

// File: tb/tb_traffic_light_controller.sv
// tb_traffic_light_controller: directed checks of phase sequence, reset, safety and minimum timing
module tb_traffic_light_controller;
  logic clk, clk_en, rst;
  logic [2:0] ns_a, ew_a, ns_b, ew_b;
  int vectors, miscompares;

  traffic_light_controller dut_a (.clk(clk), .rst(rst), .ns(ns_a), .ew(ew_a));
  traffic_light_controller #(.GREEN_CYCLES(1), .YELLOW_CYCLES(1), .ALLRED_CYCLES(0))
    dut_b (.clk(clk), .rst(rst), .ns(ns_b), .ew(ew_b));

  initial begin
    clk = 1'b0;
    forever #5 if (clk_en) clk = ~clk;
  end

  function automatic logic [5:0] model(int t, int g, int y, int a);
    int gg, yy, aa, per, k;
    gg = (g < 1) ? 1 : g;
    yy = (y < 1) ? 1 : y;
    aa = (a < 1) ? 1 : a;
`ifndef TLC_ALL_RED_EN
    aa = 0;
`endif
    per = 2 * (gg + yy + aa);
    k = t % per;
    if (k < gg) return {3'b001, 3'b100};
    k -= gg;
    if (k < yy) return {3'b010, 3'b100};
    k -= yy;
    if (k < aa) return {3'b100, 3'b100};
    k -= aa;
    if (k < gg) return {3'b100, 3'b001};
    k -= gg;
    if (k < yy) return {3'b100, 3'b010};
    return {3'b100, 3'b100};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clk_en = 1'b0;
    rst = 1'b0;
    #3;
    vectors++;
    if ({ns_a, ew_a} !== 6'b001_100) begin
      miscompares++;
      $display("FAIL reset_no_clk: ns/ew=%b/%b expected 001/100", ns_a, ew_a);
    end
    #20;
    vectors++;
    if ({ns_b, ew_b} !== 6'b001_100) begin
      miscompares++;
      $display("FAIL reset_no_clk_b: ns/ew=%b/%b expected 001/100", ns_b, ew_b);
    end
    clk_en = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if ({ns_a, ew_a} !== 6'b001_100) begin
      miscompares++;
      $display("FAIL reset_held: ns/ew=%b/%b expected 001/100", ns_a, ew_a);
    end
  endtask

  task automatic test_full_cycle();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 48; t++) begin
      exp = model(t, 5, 2, 1);
      vectors++;
      if ({ns_a, ew_a} !== exp) begin
        miscompares++;
        $display("FAIL full_cycle t=%0d: ns/ew=%b/%b expected %b/%b", t, ns_a, ew_a, exp[5:3], exp[2:0]);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid_phase();
    bit found;
    found = 1'b0;
    do_reset();
    for (int i = 0; i < 50 && !found; i++) begin
      if (ew_a == 3'b001) found = 1'b1;
      else begin
        @(negedge clk);
        #1;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL mid_reset_wait: EW_GREEN not reached within 50 cycles, ew=%b expected 001", ew_a);
    end
    #1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({ns_a, ew_a} !== 6'b001_100) begin
      miscompares++;
      $display("FAIL mid_reset: ns/ew=%b/%b expected 001/100", ns_a, ew_a);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int t = 0; t < 6; t++) begin
      vectors++;
      if ({ns_a, ew_a} !== model(t, 5, 2, 1)) begin
        miscompares++;
        $display("FAIL post_reset_green t=%0d: ns/ew=%b/%b expected %b", t, ns_a, ew_a, model(t, 5, 2, 1));
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_min_timing();
    logic [5:0] exp;
    do_reset();
    for (int t = 0; t < 24; t++) begin
      exp = model(t, 1, 1, 0);
      vectors++;
      if ({ns_b, ew_b} !== exp) begin
        miscompares++;
        $display("FAIL min_timing t=%0d: ns/ew=%b/%b expected %b/%b", t, ns_b, ew_b, exp[5:3], exp[2:0]);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_safety();
    do_reset();
    for (int t = 0; t < 1000; t++) begin
      vectors++;
      if ($countones(ns_a) != 1 || $countones(ew_a) != 1 || (ns_a != 3'b100 && ew_a != 3'b100)) begin
        miscompares++;
        $display("FAIL safety_a t=%0d: ns/ew=%b/%b expected one-hot with one side red", t, ns_a, ew_a);
      end
      vectors++;
      if ($countones(ns_b) != 1 || $countones(ew_b) != 1 || (ns_b != 3'b100 && ew_b != 3'b100)) begin
        miscompares++;
        $display("FAIL safety_b t=%0d: ns/ew=%b/%b expected one-hot with one side red", t, ns_b, ew_b);
      end
      @(negedge clk);
      #1;
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    clk_en = 1'b0;
    rst = 1'b0;
    test_reset();
    test_full_cycle();
    test_reset_mid_phase();
    test_min_timing();
    test_safety();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/traffic_light_controller.md
TRAFFIC_LIGHT_CONTROLLER -- requirements
Module: traffic_light_controller

Interface
REQ-001 Parameter GREEN_CYCLES, default 5: green phase length in clock cycles; legal range 1..255.
REQ-002 Parameter YELLOW_CYCLES, default 2: yellow phase length in clock cycles; legal range 1..255.
REQ-003 Parameter ALLRED_CYCLES, default 1: all-red clearance length in clock cycles; legal range 1..255.
REQ-004 clk  input  1  single clock; all state changes occur on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 ns  output  3  north-south lamps: bit2 = red, bit1 = yellow, bit0 = green.
REQ-007 ew  output  3  east-west lamps: same bit encoding as ns.

Function
REQ-008 The block SHALL be a Moore FSM with phases NS_GREEN -> NS_YELLOW -> ALL_RED_1 -> EW_GREEN -> EW_YELLOW -> ALL_RED_2 -> NS_GREEN, repeating with no external inputs.
REQ-009 Lamp outputs per phase SHALL be:
- NS_GREEN: ns=001, ew=100.
- NS_YELLOW: ns=010, ew=100.
- ALL_RED_x: ns=100, ew=100.
- EW_GREEN: ns=100, ew=001.
- EW_YELLOW: ns=100, ew=010.
REQ-010 Outputs SHALL be registered or decoded only from the state register, with no combinational path from any input.
REQ-011 An 8-bit down-counter SHALL load (phase length - 1) on phase entry and decrement each cycle; the phase SHALL advance on the edge where the counter is 0. Each phase therefore lasts exactly its parameter value in cycles.
REQ-012 A parameter value of 0 SHALL behave as 1.
REQ-013 Each output SHALL be one-hot at all times.
REQ-014 ns and ew SHALL never both be non-red in the same cycle.
REQ-015 Unreachable state encodings SHALL recover to NS_GREEN on the next clock edge.

Reset
REQ-016 While rst=0, the block SHALL be in NS_GREEN with ns=001 and ew=100 immediately, without waiting for a clock edge.
REQ-017 On reset, the counter SHALL be loaded with GREEN_CYCLES-1.
REQ-018 Reset asserted mid-phase SHALL abort that phase at once.
REQ-019 After rst deasserts, NS_GREEN SHALL last a full GREEN_CYCLES cycles.

Configuration
REQ-020 With macro TLC_ALL_RED_EN defined, the ALL_RED_1 and ALL_RED_2 phases SHALL be present as in REQ-008.
REQ-021 With TLC_ALL_RED_EN undefined, NS_YELLOW SHALL go directly to EW_GREEN and EW_YELLOW directly to NS_GREEN; ALLRED_CYCLES SHALL then be ignored.

Structure
REQ-022 Package tlc_pkg SHALL hold the phase-state enum typedef, the lamp encodings (LAMP_RED=100, LAMP_YELLOW=010, LAMP_GREEN=001) and the counter width constant (8).
REQ-023 The phase down-counter SHALL be a sub-module named tlc_phase_timer, with ports: load, load value, and a zero flag.
REQ-024 The FSM and output decode SHALL live in traffic_light_controller.

Verification (default parameters)
REQ-025 Reset behaviour:
- Stimulus: hold rst=0 with no clock edges.
- Required response: ns=001, ew=100.
- Stimulus: assert rst=0 during EW_GREEN.
- Required response: outputs switch to ns=001, ew=100 before the next clock edge.
REQ-026 Full cycle with TLC_ALL_RED_EN defined:
- Stimulus: release reset and run.
- Required response, in cycles after release: ns=001 for 5, ns=010 for 2, both red for 1, ew=001 for 5, ew=010 for 2, both red for 1.
- The sequence SHALL repeat with a period of 16 cycles.
REQ-027 Full cycle with TLC_ALL_RED_EN undefined:
- Stimulus: release reset and run.
- Required response: same sequence without the all-red phases; period of 14 cycles.
REQ-028 Safety assertions over 1000 cycles:
- Both outputs one-hot in every cycle.
- Never ns!=100 and ew!=100 in the same cycle.
REQ-029 Minimum timing:
- Stimulus: GREEN_CYCLES=1, YELLOW_CYCLES=1, ALLRED_CYCLES=0.
- Required response: every phase lasts 1 cycle; period of 6 cycles.
